label_ram_wr_ctrl: RTL and testbench



---
 rtl/label_ram_wr_ctrl_pkg.sv | 15 +
 rtl/label_ram_wr_ctrl_if.sv | 28 ++
 rtl/label_ram_wr_ctrl_rr_arb2.sv | 23 ++
 rtl/label_ram_wr_ctrl.sv | 132 +++++++++++++
 tb/tb_label_ram_wr_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/label_ram_wr_ctrl_pkg.sv
// Shared types and frame constants for the label RAM write path.
package label_ram_pkg;
  localparam int FRAME_W      = 320;
  localparam int FRAME_H      = 240;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int ADDR_W       = 17;
  localparam int DATA_W       = 3;

  typedef logic [DATA_W-1:0] label_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam label_t CLEAR_LABEL = 3'd0;

  typedef enum logic [1:0] {ARB, CLEAR, CLR_LAST} wr_state_e;
endpackage

// File: rtl/label_ram_wr_ctrl_if.sv
// Requester handshakes plus the RAM write port of the label RAM controller.
interface label_ram_wr_ctrl_if;
  import label_ram_pkg::*;

  // valid/ready: a write transfers in any cycle where valid and ready are both
  // high; the requester holds addr/data stable while valid is high and ready low.
  logic   req0_valid;
  logic   req0_ready;
  addr_t  req0_addr;
  label_t req0_data;
  logic   req1_valid;
  logic   req1_ready;
  addr_t  req1_addr;
  label_t req1_data;
  logic   ram_we;
  addr_t  ram_w_addr;
  label_t ram_w_data;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, ram_we, ram_w_addr, ram_w_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, ram_we, ram_w_addr, ram_w_data
  );
endinterface

// File: rtl/label_ram_wr_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; a grant is an accept, so the pointer moves on every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic last_one;  // requester 1 was granted most recently

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) grant = last_one ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       last_one <= 1'b1;
    else if (|grant) last_one <= grant[1];
  end
endmodule

// File: rtl/label_ram_wr_ctrl.sv
// Label RAM write-port controller: round-robin sharing of two requesters plus a frame-clear sweep.
// Optional statistics counters are built when LABEL_RAM_WR_STATS_EN is defined.
module label_ram_wr_ctrl
  import label_ram_pkg::ADDR_W, label_ram_pkg::addr_t, label_ram_pkg::label_t,
         label_ram_pkg::wr_state_e, label_ram_pkg::ARB, label_ram_pkg::CLEAR,
         label_ram_pkg::CLR_LAST, label_ram_pkg::CLEAR_LABEL;
#(
  parameter int FRAME_PIXELS = label_ram_pkg::FRAME_PIXELS
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clear_start,
  output logic      clear_busy,
  output logic      clear_done,
  output logic      addr_err,
  output wr_state_e fsm_state,
  label_ram_wr_ctrl_if.slave bus
`ifdef LABEL_RAM_WR_STATS_EN
  ,
  output logic [ADDR_W:0] wr_count,
  output logic [15:0]     conflict_cnt
`endif
);
  localparam addr_t LAST_ADDR = addr_t'(FRAME_PIXELS - 1);

  wr_state_e  state, state_nxt;
  addr_t      cnt, sel_addr, addr_q;
  label_t     sel_data, data_q;
  logic       arb_en, clr_acc, in_range, we_q, err_q;
  logic [1:0] grant;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:      if (clear_start)      state_nxt = CLEAR;
      CLEAR:    if (cnt == LAST_ADDR) state_nxt = CLR_LAST;
      CLR_LAST: state_nxt = ARB;
      default:  state_nxt = ARB;
    endcase
  end

  // CLR_LAST only drains the final clear write, so arbitration is already live there.
  always_comb begin
    arb_en     = 1'b0;
    clr_acc    = 1'b0;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (state)
      ARB: begin
        clr_acc = clear_start;
        arb_en  = !clear_start;
      end
      CLEAR: clear_busy = 1'b1;
      CLR_LAST: begin
        clear_busy = 1'b1;
        clear_done = 1'b1;
        arb_en     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_addr = grant[1] ? bus.req1_addr : bus.req0_addr;
    sel_data = grant[1] ? bus.req1_data : bus.req0_data;
    in_range = (32'(sel_addr) < 32'(FRAME_PIXELS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      if (state == CLEAR) begin
        we_q   <= 1'b1;
        addr_q <= cnt;
        data_q <= CLEAR_LABEL;
        if (cnt != LAST_ADDR) cnt <= cnt + 1'b1;
      end else begin
        if (clr_acc) cnt <= '0;
        if (|grant) begin
          if (in_range) begin
            we_q   <= 1'b1;
            addr_q <= sel_addr;
            data_q <= sel_data;
          end else begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.ram_we     = we_q;
  assign bus.ram_w_addr = addr_q;
  assign bus.ram_w_data = data_q;
  assign addr_err       = err_q;
  assign fsm_state      = state;

`ifdef LABEL_RAM_WR_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || clr_acc) begin
      wr_count     <= '0;
      conflict_cnt <= '0;
    end else begin
      if ((|grant) && in_range && (wr_count != '1)) wr_count <= wr_count + 1'b1;
      if ((state == ARB) && bus.req0_valid && bus.req1_valid && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_label_ram_wr_ctrl.sv
// Bench for label_ram_wr_ctrl: vector table, directed sweep/reset sequences, random run against a timeline model.
module tb_label_ram_wr_ctrl;
  import label_ram_pkg::*;

  localparam int FP = 8;
  localparam int W  = 22;  // {we, err, addr, data}

  typedef struct {
    int v0, a0, d0, v1, a1, d1, clr;
    int r0, r1, we, wa, wd, err;
  } vec_t;

  logic      clk = 1'b0;
  logic      reset, clear_start, busy, done, err;
  wr_state_e st;
  logic      full_clr, full_busy, full_done, full_err;
  wr_state_e full_st;
`ifdef LABEL_RAM_WR_STATS_EN
  logic [ADDR_W:0] wr_count, full_wr_count;
  logic [15:0]     conflict_cnt, full_conflict_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  label_ram_wr_ctrl_if bus();
  label_ram_wr_ctrl_if bus_full();

  label_ram_wr_ctrl #(.FRAME_PIXELS(FP)) dut (
    .clk(clk), .reset(reset), .clear_start(clear_start), .clear_busy(busy),
    .clear_done(done), .addr_err(err), .fsm_state(st), .bus(bus)
`ifdef LABEL_RAM_WR_STATS_EN
    , .wr_count(wr_count), .conflict_cnt(conflict_cnt)
`endif
  );

  label_ram_wr_ctrl dut_full (
    .clk(clk), .reset(reset), .clear_start(full_clr), .clear_busy(full_busy),
    .clear_done(full_done), .addr_err(full_err), .fsm_state(full_st), .bus(bus_full)
`ifdef LABEL_RAM_WR_STATS_EN
    , .wr_count(full_wr_count), .conflict_cnt(full_conflict_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver
  task automatic set_in(input int v0, input int a0, input int d0,
                        input int v1, input int a1, input int d1, input int clr);
    bus.req0_valid = (v0 != 0);
    bus.req0_addr  = addr_t'(a0);
    bus.req0_data  = label_t'(d0);
    bus.req1_valid = (v1 != 0);
    bus.req1_addr  = addr_t'(a1);
    bus.req1_data  = label_t'(d1);
    clear_start    = (clr != 0);
  endtask

  task automatic do_reset(input string tag);
    next_cycle();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    sample();
    check({tag, "_rst_we"},    32'(bus.ram_we), 0);
    check({tag, "_rst_addr"},  32'(bus.ram_w_addr), 0);
    check({tag, "_rst_busy"},  32'(busy), 0);
    check({tag, "_rst_done"},  32'(done), 0);
    check({tag, "_rst_err"},   32'(err), 0);
    check({tag, "_rst_state"}, 32'(st), 32'(ARB));
  endtask

  // scoreboard: next-cycle registered outputs predicted by the model
  logic [W-1:0] exp_q[$];

  vec_t vt[10];

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    full_clr = 1'b0;
    bus_full.req0_valid = 1'b0; bus_full.req0_addr = '0; bus_full.req0_data = '0;
    bus_full.req1_valid = 1'b0; bus_full.req1_addr = '0; bus_full.req1_data = '0;

    //        v0 a0 d0 v1 a1 d1 clr  r0 r1 we wa wd err
    vt[0] = '{1, 5, 3, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    vt[1] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 5, 3, 0};
    vt[2] = '{1, 1, 1, 1, 2, 2, 0,   0, 1, 0, 0, 0, 0};
    vt[3] = '{1, 1, 1, 1, 3, 4, 0,   1, 0, 1, 2, 2, 0};
    vt[4] = '{0, 0, 0, 1, 3, 4, 0,   0, 1, 1, 1, 1, 0};
    vt[5] = '{0, 0, 0, 1, 8, 5, 0,   0, 1, 1, 3, 4, 0};
    vt[6] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1};
    vt[7] = '{1, 7, 6, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    vt[8] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 7, 6, 0};
    vt[9] = '{1, 2, 1, 1, 3, 1, 1,   0, 0, 0, 0, 0, 0};

    do_reset("tbl");
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      set_in(vt[i].v0, vt[i].a0, vt[i].d0, vt[i].v1, vt[i].a1, vt[i].d1, vt[i].clr);
      sample();
      check($sformatf("vec%0d_r0", i),  32'(bus.req0_ready), vt[i].r0);
      check($sformatf("vec%0d_r1", i),  32'(bus.req1_ready), vt[i].r1);
      check($sformatf("vec%0d_we", i),  32'(bus.ram_we), vt[i].we);
      check($sformatf("vec%0d_err", i), 32'(err), vt[i].err);
      if (vt[i].we != 0) begin
        check($sformatf("vec%0d_addr", i), 32'(bus.ram_w_addr), vt[i].wa);
        check($sformatf("vec%0d_data", i), 32'(bus.ram_w_data), vt[i].wd);
      end
    end

    // fairness: both held valid, grants alternate starting with requester 0
    begin
      int g0, g1, prev_a, prev_d;
      do_reset("fair");
      g0 = 0; g1 = 0; prev_a = -1; prev_d = 0;
      for (int i = 0; i < 7; i++) begin
        next_cycle();
        set_in(i < 6 ? 1 : 0, g0, g0 + 1, i < 6 ? 1 : 0, 4 + g1, g1 + 5, 0);
        sample();
        if (i < 6) begin
          check($sformatf("fair%0d_r0", i), 32'(bus.req0_ready), (i % 2 == 0) ? 1 : 0);
          check($sformatf("fair%0d_r1", i), 32'(bus.req1_ready), (i % 2 == 1) ? 1 : 0);
        end
        if (i > 0) begin
          check($sformatf("fair%0d_we", i),   32'(bus.ram_we), 1);
          check($sformatf("fair%0d_addr", i), 32'(bus.ram_w_addr), prev_a);
          check($sformatf("fair%0d_data", i), 32'(bus.ram_w_data), prev_d);
        end
        if (i % 2 == 0) begin prev_a = g0; prev_d = g0 + 1; g0++; end
        else            begin prev_a = 4 + g1; prev_d = g1 + 5; g1++; end
      end
    end

    // clear sweep with a pending req0 and an ignored second clear_start
    do_reset("clr");
    next_cycle();
    set_in(1, 4, 2, 0, 0, 0, 1);
    sample();
    check("clr_t_r0", 32'(bus.req0_ready), 0);
    check("clr_t_busy", 32'(busy), 0);
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      set_in(k <= 9 ? 1 : 0, 4, 2, 0, 0, 0, k == 3 ? 1 : 0);
      sample();
      check($sformatf("clr%0d_busy", k), 32'(busy), k <= 9 ? 1 : 0);
      check($sformatf("clr%0d_done", k), 32'(done), k == 9 ? 1 : 0);
      check($sformatf("clr%0d_r0", k),   32'(bus.req0_ready), k == 9 ? 1 : 0);
      check($sformatf("clr%0d_we", k),   32'(bus.ram_we), k >= 2 ? 1 : 0);
      if (k >= 2) begin
        check($sformatf("clr%0d_addr", k), 32'(bus.ram_w_addr), k <= 9 ? k - 2 : 4);
        check($sformatf("clr%0d_data", k), 32'(bus.ram_w_data), k <= 9 ? 0 : 2);
      end
    end

    // reset in the middle of a sweep
    do_reset("rms");
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      if (k == 4) reset = 1'b1;
      sample();
      check($sformatf("rms%0d_busy", k), 32'(busy), 1);
    end
    next_cycle();
    reset = 1'b0;
    sample();
    check("rms_we", 32'(bus.ram_we), 0);
    check("rms_busy", 32'(busy), 0);
    check("rms_done", 32'(done), 0);
    check("rms_state", 32'(st), 32'(ARB));
    for (int k = 6; k <= 14; k++) begin
      next_cycle();
      sample();
      check($sformatf("rms%0d_done", k), 32'(done), 0);
      check($sformatf("rms%0d_we", k),   32'(bus.ram_we), 0);
    end

    // random traffic against a timeline model of the controller
    begin
      int  v0, a0, d0, v1, a1, d1, clr, g, t0, last_g;
      bit  sw;
      logic busy_w, block_w, clr_acc, allow;
      logic [W-1:0] e;
      do_reset("rnd");
      exp_q.delete();
      exp_q.push_back('0);
      sw = 0; t0 = 0; last_g = 1;
      v0 = 0; a0 = 0; d0 = 0; v1 = 0; a1 = 0; d1 = 0;
      for (int c = 0; c < 600; c++) begin
        next_cycle();
        clr = ($urandom_range(0, 39) == 0) ? 1 : 0;
        set_in(v0, a0, d0, v1, a1, d1, clr);
        busy_w  = sw && (c >= t0 + 1) && (c <= t0 + FP + 1);
        block_w = sw && (c >= t0 + 1) && (c <= t0 + FP);
        clr_acc = (clr != 0) && !busy_w;
        allow   = !clr_acc && !block_w;
        g = -1;
        if (allow) begin
          if (v0 != 0 && v1 != 0) g = (last_g == 1) ? 0 : 1;
          else if (v0 != 0)       g = 0;
          else if (v1 != 0)       g = 1;
        end
        sample();
        e = exp_q.pop_front();
        check("rnd_r0",   32'(bus.req0_ready), (g == 0) ? 1 : 0);
        check("rnd_r1",   32'(bus.req1_ready), (g == 1) ? 1 : 0);
        check("rnd_busy", 32'(busy), 32'(busy_w));
        check("rnd_done", 32'(done), (sw && c == t0 + FP + 1) ? 1 : 0);
        check("rnd_we",   32'(bus.ram_we), 32'(e[W-1]));
        check("rnd_err",  32'(err), 32'(e[W-2]));
        if (e[W-1]) begin
          check("rnd_addr", 32'(bus.ram_w_addr), 32'(e[W-3:3]));
          check("rnd_data", 32'(bus.ram_w_data), 32'(e[2:0]));
        end
        if (block_w)
          exp_q.push_back({1'b1, 1'b0, addr_t'(c - t0 - 1), CLEAR_LABEL});
        else if (g >= 0) begin
          int ga, gd;
          ga = (g == 0) ? a0 : a1;
          gd = (g == 0) ? d0 : d1;
          if (ga < FP) exp_q.push_back({1'b1, 1'b0, addr_t'(ga), label_t'(gd)});
          else         exp_q.push_back({1'b0, 1'b1, addr_t'(0), label_t'(0)});
          last_g = g;
        end else
          exp_q.push_back('0);
        if (clr_acc) begin sw = 1; t0 = c; end
        if (!(v0 != 0 && g != 0)) begin
          v0 = int'($urandom_range(0, 1)); a0 = int'($urandom_range(0, FP + 1)); d0 = int'($urandom_range(0, 7));
        end
        if (!(v1 != 0 && g != 1)) begin
          v1 = int'($urandom_range(0, 1)); a1 = int'($urandom_range(0, FP + 1)); d1 = int'($urandom_range(0, 7));
        end
      end
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0);
    end

    // full-size smoke: last valid address and first out-of-range address
    next_cycle();
    bus_full.req0_valid = 1'b1; bus_full.req0_addr = addr_t'(76799); bus_full.req0_data = 3'd5;
    sample();
    check("full_r0", 32'(bus_full.req0_ready), 1);
    next_cycle();
    bus_full.req0_valid = 1'b0;
    bus_full.req1_valid = 1'b1; bus_full.req1_addr = addr_t'(76800); bus_full.req1_data = 3'd1;
    sample();
    check("full_r1", 32'(bus_full.req1_ready), 1);
    check("full_we", 32'(bus_full.ram_we), 1);
    check("full_addr", 32'(bus_full.ram_w_addr), 76799);
    check("full_data", 32'(bus_full.ram_w_data), 5);
    next_cycle();
    bus_full.req1_valid = 1'b0;
    sample();
    check("full_oor_we", 32'(bus_full.ram_we), 0);
    check("full_oor_err", 32'(full_err), 1);
    check("full_busy", 32'(full_busy), 0);
    check("full_done", 32'(full_done), 0);
    check("full_state", 32'(full_st), 32'(ARB));

`ifdef LABEL_RAM_WR_STATS_EN
    do_reset("stat");
    next_cycle(); set_in(1, 1, 1, 1, 2, 2, 0);
    next_cycle(); set_in(1, 3, 3, 1, 2, 2, 0);
    next_cycle(); set_in(1, 3, 3, 0, 0, 0, 0);
    next_cycle(); set_in(0, 0, 0, 1, 8, 1, 0);
    next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    sample();
    check("stat_wr_count", 32'(wr_count), 3);
    check("stat_conflict", 32'(conflict_cnt), 2);
    next_cycle(); set_in(0, 0, 0, 0, 0, 0, 1);
    next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0);
    sample();
    check("stat_wr_clr", 32'(wr_count), 0);
    check("stat_conf_clr", 32'(conflict_cnt), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
